// File: rtl/ukp_seq_if.sv
// ukp_seq_if: transmitter request/accept channel between the microcode
// sequencer and the USB line serializer.
//   tx_valid  sequencer -> serializer  request pending
//   tx_ready  serializer -> sequencer  request accepted this clk
//   tx_cmd    sequencer -> serializer  0=byte, 1=EOP, 2=hold SE0, 3=release
//   tx_data   sequencer -> serializer  byte (cmd 0) or EOP immediate (cmd 1)
// master = sequencer side, slave = serializer side.
interface ukp_seq_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_cmd;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_cmd, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_cmd, input tx_data, output tx_ready);
endinterface

// File: rtl/ukp_seq.sv
// ukp_seq: microcode sequencer for the USB low-speed keyboard/pad host.
// Fetches 4-bit nibbles from the program ROM (two clks per nibble: present
// address, then sample data), decodes/executes them and drives the line
// transmitter request channel plus receiver control pulses.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   rom_adr   nibble address to ROM (ROM answers on the following clk)
//   rom_data  ROM nibble
//   tick_1ms  one-clk frame pulse (releases the wait opcode)
//   conn_i    device-connected status (bc)
//   act_i     bus-activity status (bz)
//   nak_i     last handshake NAK/timeout (bnak)
//   tx        transmitter request channel (ukp_seq_if.master)
//   rx_start  one-clk pulse: clear receiver
//   rx_en     one-clk pulse: arm receiver
//   tgl       toggle flag
//
// Build option
//   UKP_TXTO_EN  when defined, a transmitter request left unaccepted for
//                TX_TIMEOUT consecutive clks is abandoned (pc and retpc
//                return to 0, cnt and tgl are kept). Without it the
//                sequencer waits for tx_ready indefinitely.
module ukp_seq #(
  parameter int unsigned ADR_W      = 14,
  parameter int unsigned TX_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ADR_W-1:0] rom_adr,
  input  logic [3:0]       rom_data,
  input  logic             tick_1ms,
  input  logic             conn_i,
  input  logic             act_i,
  input  logic             nak_i,
  ukp_seq_if.master        tx,
  output logic             rx_start,
  output logic             rx_en,
  output logic             tgl
);

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_IMM,
    EXEC,
    TX_WAIT,
    TICK_WAIT
  } state_t;

  state_t           r_state;
  logic             r_ph;      // 0: address presented, 1: ROM data valid
  logic [3:0]       r_op;
  logic [1:0]       r_nib;     // immediate nibble index, LSN first
  logic [11:0]      r_imm;
  logic             r_cond;    // branch condition captured with last target nibble
  logic [ADR_W-1:0] r_pc;
  logic [ADR_W-1:0] r_retpc;
  logic [7:0]       r_cnt;
  logic             r_valid;
  logic [1:0]       r_cmd;
  logic [7:0]       r_data;
  logic             r_rxs;
  logic             r_rxe;
  logic             r_tgl;

`ifdef UKP_TXTO_EN
  localparam int unsigned TO_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  logic [TO_W-1:0] r_to;
`else
  // Timeout logic absent; the parameter stays so both builds share one
  // instantiation.
  if (TX_TIMEOUT == 0) begin : g_txto_unused
  end
`endif

  // Number of immediate nibbles following each opcode.
  function automatic logic [1:0] imm_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h3, 4'h6, 4'h8, 4'h9, 4'ha, 4'hb: imm_len = 2'd2;
      4'hf:                                     imm_len = 2'd3;
      default:                                  imm_len = 2'd0;
    endcase
  endfunction

  logic [1:0]       w_last_nib;
  logic             w_cond;
  logic [ADR_W-1:0] w_pc_inc;
  logic [ADR_W-1:0] w_br_dest;
  logic [ADR_W-1:0] w_call_dest;
  logic [7:0]       w_cnt_dec;

  assign w_last_nib  = imm_len(r_op) - 2'd1;
  assign w_pc_inc    = r_pc + ADR_W'(1);
  // Targets are word-aligned and zero-extended to the ROM address width.
  assign w_br_dest   = ADR_W'({r_imm[7:0], 2'b00});
  assign w_call_dest = ADR_W'({r_imm, 2'b00});
  assign w_cnt_dec   = r_cnt - 8'd1;

  always_comb begin
    w_cond = 1'b0;
    case (r_op)
      4'h8:    w_cond = act_i;
      4'h9:    w_cond = conn_i;
      4'ha:    w_cond = nak_i;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH_OP;
      r_ph    <= 1'b0;
      r_op    <= '0;
      r_nib   <= '0;
      r_imm   <= '0;
      r_cond  <= 1'b0;
      r_pc    <= '0;
      r_retpc <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_data  <= '0;
      r_rxs   <= 1'b0;
      r_rxe   <= 1'b0;
      r_tgl   <= 1'b0;
`ifdef UKP_TXTO_EN
      r_to    <= '0;
`endif
    end else begin
      r_rxs <= 1'b0;
      r_rxe <= 1'b0;

      case (r_state)
        FETCH_OP: begin
          if (!r_ph) begin
            r_ph <= 1'b1;
          end else begin
            r_ph  <= 1'b0;
            r_op  <= rom_data;
            r_nib <= '0;
            r_pc  <= w_pc_inc;
            if (imm_len(rom_data) == 2'd0) r_state <= EXEC;
            else                           r_state <= FETCH_IMM;
          end
        end

        FETCH_IMM: begin
          if (!r_ph) begin
            r_ph <= 1'b1;
          end else begin
            r_ph  <= 1'b0;
            r_pc  <= w_pc_inc;
            r_nib <= r_nib + 2'd1;
            case (r_nib)
              2'd0:    r_imm[3:0]  <= rom_data;
              2'd1:    r_imm[7:4]  <= rom_data;
              default: r_imm[11:8] <= rom_data;
            endcase
            if (r_nib == w_last_nib) begin
              r_cond  <= w_cond;
              r_state <= EXEC;
            end
          end
        end

        EXEC: begin
          r_state <= FETCH_OP;
`ifdef UKP_TXTO_EN
          r_to    <= '0;
`endif
          case (r_op)
            4'h1: r_cnt <= r_imm[7:0];
            4'h2: r_rxs <= 1'b1;
            4'h3: begin
              r_valid <= 1'b1;
              r_cmd   <= 2'd1;
              r_data  <= r_imm[7:0];
              r_state <= TX_WAIT;
            end
            4'h4: begin
              r_valid <= 1'b1;
              r_cmd   <= 2'd2;
              r_data  <= '0;
              r_state <= TX_WAIT;
            end
            4'h5: begin
              r_valid <= 1'b1;
              r_cmd   <= 2'd3;
              r_data  <= '0;
              r_state <= TX_WAIT;
            end
            4'h6: begin
              r_valid <= 1'b1;
              r_cmd   <= 2'd0;
              r_data  <= r_imm[7:0];
              r_state <= TX_WAIT;
            end
            4'h7: r_pc <= r_retpc;
            4'h8, 4'h9, 4'ha: begin
              if (r_cond) r_pc <= w_br_dest;
            end
            4'hb: begin
              // cnt=0 wraps to 255, which is non-zero, so the branch is taken.
              r_cnt <= w_cnt_dec;
              if (w_cnt_dec != 8'd0) r_pc <= w_br_dest;
            end
            4'hc: r_tgl <= ~r_tgl;
            4'hd: r_rxe <= 1'b1;
            4'he: begin
              // A tick in this very clk releases the wait; earlier ticks are lost.
              if (!tick_1ms) r_state <= TICK_WAIT;
            end
            4'hf: begin
              // r_pc already points past the four call nibbles.
              r_retpc <= r_pc;
              r_pc    <= w_call_dest;
            end
            default: ;
          endcase
        end

        TX_WAIT: begin
          if (tx.tx_ready) begin
            r_valid <= 1'b0;
            r_state <= FETCH_OP;
          end
`ifdef UKP_TXTO_EN
          else if (r_to == TO_W'(TX_TIMEOUT - 1)) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_retpc <= '0;
            r_state <= FETCH_OP;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
`endif
        end

        TICK_WAIT: begin
          if (tick_1ms) r_state <= FETCH_OP;
        end

        default: r_state <= FETCH_OP;
      endcase
    end
  end

  assign rom_adr     = r_pc;
  assign tx.tx_valid = r_valid;
  assign tx.tx_cmd   = r_cmd;
  assign tx.tx_data  = r_data;
  assign rx_start    = r_rxs;
  assign rx_en       = r_rxe;
  assign tgl         = r_tgl;

endmodule

// File: tb/tb_ukp_seq.sv
// tb_ukp_seq: directed boundary checks plus randomized programs compared
// against an instruction-level reference interpreter of the nibble ISA.
`timescale 1ns/1ps
module tb_ukp_seq;
  localparam int unsigned ADR_W = 14;
  localparam int unsigned DEPTH = 1 << ADR_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [ADR_W-1:0] rom_adr;
  logic [3:0]       rom_data;
  logic             tick_1ms;
  logic             conn_i;
  logic             act_i;
  logic             nak_i;
  logic             rx_start;
  logic             rx_en;
  logic             tgl;

  ukp_seq_if tx_if();

  ukp_seq #(.ADR_W(ADR_W), .TX_TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .rom_adr  (rom_adr),
    .rom_data (rom_data),
    .tick_1ms (tick_1ms),
    .conn_i   (conn_i),
    .act_i    (act_i),
    .nak_i    (nak_i),
    .tx       (tx_if.master),
    .rx_start (rx_start),
    .rx_en    (rx_en),
    .tgl      (tgl)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [DEPTH];
  always @(posedge clk) rom_data <= mem[rom_adr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed event stream: [11:10] type (0 tx accept, 1 rx_start, 2 rx_en, 3 tgl change)
  logic [11:0] q_dut[$];
  logic [11:0] q_exp[$];
  int unsigned q_base = 0;
  logic        tgl_q  = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_if.tx_valid && tx_if.tx_ready)
        q_dut.push_back({2'd0, tx_if.tx_cmd, (tx_if.tx_cmd < 2'd2) ? tx_if.tx_data : 8'h00});
      if (rx_start) q_dut.push_back({2'd1, 10'd0});
      if (rx_en)    q_dut.push_back({2'd2, 10'd0});
      if (tgl !== tgl_q) q_dut.push_back({2'd3, 9'd0, tgl});
    end
    tgl_q = tgl;
  end

  function automatic int unsigned n_ev(input logic [1:0] ty);
    int unsigned c;
    c = 0;
    for (int unsigned i = q_base; i < q_dut.size(); i++)
      if (q_dut[i][11:10] == ty) c++;
    return c;
  endfunction

  task automatic clear_mem();
    for (int unsigned a = 0; a < DEPTH; a++) mem[a] = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_1ms = 1'b0;
    tx_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q_base = q_dut.size();
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_adr(input logic [ADR_W-1:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rom_adr == a) ok = 1'b1;
    end
  endtask

  task automatic next_adr(input logic [ADR_W-1:0] s0, input logic [ADR_W-1:0] s1,
                          output logic [ADR_W-1:0] got);
    got = '1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rom_adr != s0 && rom_adr != s1) begin
        got = rom_adr;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (tx_if.tx_valid) ok = 1'b1;
    end
  endtask

  // Conditional branch to 0x034 (rx_en there) vs fall-through (toggle at 0x003).
  task automatic run_cond(input string tag, input logic [3:0] op, input logic val);
    clear_mem();
    mem[0] = op; mem[1] = 4'hd; mem[2] = 4'h0;
    mem[3] = 4'hc; mem[4] = 4'he;
    mem[14'h034] = 4'hd; mem[14'h035] = 4'he;
    act_i = ~val; conn_i = ~val; nak_i = ~val;
    case (op)
      4'h8:    act_i  = val;
      4'h9:    conn_i = val;
      default: nak_i  = val;
    endcase
    do_reset();
    cycles(60);
    check(tag, {n_ev(2'd2), n_ev(2'd3)}, val ? {32'd1, 32'd0} : {32'd0, 32'd1});
  endtask

  // Instruction-level interpreter: executes the program in mem and lists
  // the externally visible events in order.
  task automatic model_run(input logic a_act, input logic a_conn, input logic a_nak);
    int unsigned pc, retpc, cnt, imm, n;
    logic        tg;
    logic [3:0]  op;
    pc = 0; retpc = 0; cnt = 0; tg = 1'b0;
    q_exp.delete();
    for (int unsigned k = 0; k < 400 && q_exp.size() < 30; k++) begin
      op = mem[pc];
      pc = (pc + 1) % DEPTH;
      n = (op == 4'hf) ? 3 : ((op inside {4'h1, 4'h3, 4'h6, 4'h8, 4'h9, 4'ha, 4'hb}) ? 2 : 0);
      imm = 0;
      for (int unsigned j = 0; j < n; j++) begin
        imm = imm | (int'(mem[pc]) << (4 * j));
        pc = (pc + 1) % DEPTH;
      end
      case (op)
        4'h1: cnt = imm & 32'hff;
        4'h2: q_exp.push_back({2'd1, 10'd0});
        4'h3: q_exp.push_back({2'd0, 2'd1, 8'(imm)});
        4'h4: q_exp.push_back({2'd0, 2'd2, 8'h00});
        4'h5: q_exp.push_back({2'd0, 2'd3, 8'h00});
        4'h6: q_exp.push_back({2'd0, 2'd0, 8'(imm)});
        4'h7: pc = retpc;
        4'h8: if (a_act)  pc = (imm & 32'hff) * 4;
        4'h9: if (a_conn) pc = (imm & 32'hff) * 4;
        4'ha: if (a_nak)  pc = (imm & 32'hff) * 4;
        4'hb: begin
          cnt = (cnt + 255) % 256;
          if (cnt != 0) pc = (imm & 32'hff) * 4;
        end
        4'hc: begin
          tg = ~tg;
          q_exp.push_back({2'd3, 9'd0, tg});
        end
        4'hd: q_exp.push_back({2'd2, 10'd0});
        4'hf: begin
          retpc = pc;
          pc = ((imm & 32'hfff) * 4) % DEPTH;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [ADR_W-1:0] trace[$];
    logic [ADR_W-1:0] got;
    bit               ok;
    bit               ticked;
    bit               want;
    int unsigned      ticks;
    int unsigned      cyc;
    int unsigned      stall;
    int unsigned      hi;

    reset = 1'b1; tick_1ms = 1'b0; tx_if.tx_ready = 1'b0;
    conn_i = 1'b0; act_i = 1'b0; nak_i = 1'b0;

    // Reset values and fetch sequence of "ldi 9; wait"
    clear_mem();
    mem[0] = 4'h1; mem[1] = 4'h9; mem[2] = 4'h0; mem[3] = 4'he;
    cycles(3);
    @(negedge clk);
    check("rst_adr", rom_adr, 0);
    check("rst_tx", {tx_if.tx_valid, tx_if.tx_cmd, tx_if.tx_data}, 0);
    check("rst_rx_tgl", {rx_start, rx_en, tgl}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    q_base = q_dut.size();
    ticked = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (trace.size() == 0 || trace[trace.size()-1] != rom_adr) trace.push_back(rom_adr);
      want = (rom_adr == 3) && !ticked;
      @(posedge clk); #1;
      tick_1ms = want;
      ticked = ticked | want;
    end
    check("fetch_len", trace.size(), 5);
    for (int unsigned i = 0; i < 5; i++)
      check("fetch_adr", (i < trace.size()) ? 32'(trace[i]) : 32'hffff, i);
    check("wait_stall", rom_adr, 4);
    tick_1ms = 1'b1; cycles(1); tick_1ms = 1'b0;
    cycles(10);
    check("wait_release", rom_adr > 4, 1);

    // ldi 3; L: wait; djnz L -> 3 ticks; then djnz from 0 -> 255, taken
    clear_mem();
    mem[0] = 4'h1; mem[1] = 4'h3; mem[2] = 4'h0;
    mem[4] = 4'he; mem[5] = 4'hb; mem[6] = 4'h1; mem[7] = 4'h0;
    mem[8] = 4'hc;
    mem[9] = 4'hb; mem[10] = 4'h4; mem[11] = 4'h0;
    mem[12] = 4'hd; mem[13] = 4'he;
    mem[16] = 4'hc; mem[17] = 4'he;
    do_reset();
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      cycles(30);
      if (n_ev(2'd3) > 0) break;
      tick_1ms = 1'b1; cycles(1); tick_1ms = 1'b0;
      ticks++;
    end
    check("djnz_ticks", ticks, 3);
    cycles(30);
    check("djnz_wrap_taken", {n_ev(2'd3), n_ev(2'd2)}, {32'd2, 32'd0});

    // call at 0x029 -> 0x090, ret -> 0x02d (nested call overwrote retpc)
    clear_mem();
    mem[0] = 4'hf; mem[1] = 4'ha; mem[2] = 4'h0; mem[3] = 4'h0;
    mem[14'h029] = 4'hf; mem[14'h02a] = 4'h4; mem[14'h02b] = 4'h2; mem[14'h02c] = 4'h0;
    mem[14'h02d] = 4'hc; mem[14'h02e] = 4'he;
    mem[14'h090] = 4'h7;
    do_reset();
    wait_adr(14'h02c, ok);
    check("call_reach", ok, 1);
    next_adr(14'h02c, 14'h02d, got);
    check("call_dest", got, 32'h090);
    next_adr(14'h090, 14'h091, got);
    check("ret_dest", got, 32'h02d);
    cycles(20);
    check("ret_tgl", n_ev(2'd3), 1);

    // ret without call returns to 0
    clear_mem();
    mem[0] = 4'hc; mem[1] = 4'h7;
    do_reset();
    cycles(60);
    check("ret_nocall", n_ev(2'd3) >= 2, 1);

    // pc wraps 0x3fff -> 0
    clear_mem();
    mem[0] = 4'hf; mem[1] = 4'hf; mem[2] = 4'hf; mem[3] = 4'hf;
    mem[14'h3fff] = 4'hc;
    do_reset();
    cycles(200);
    check("pc_wrap", n_ev(2'd3) >= 2, 1);

    // outb 0x2d held for 10 clks without ready
    clear_mem();
    mem[0] = 4'h6; mem[1] = 4'hd; mem[2] = 4'h2; mem[3] = 4'he;
    do_reset();
    wait_valid(ok);
    check("tx_rise", ok, 1);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check("tx_hold", {tx_if.tx_valid, tx_if.tx_cmd, tx_if.tx_data, 18'(rom_adr)},
            {1'b1, 2'd0, 8'h2d, 18'd3});
    end
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b0;
    @(negedge clk);
    check("tx_release", tx_if.tx_valid, 0);
    check("tx_event", (n_ev(2'd0) == 1) ? 32'(q_dut[q_base]) : 32'hfff, {2'd0, 2'd0, 8'h2d});
    cycles(10);
    check("tx_resume", rom_adr, 4);

    // async reset mid-request
    clear_mem();
    mem[0] = 4'h6; mem[1] = 4'hd; mem[2] = 4'h2; mem[3] = 4'he;
    do_reset();
    wait_valid(ok);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", {tx_if.tx_valid, 14'(rom_adr)}, 0);
    cycles(1);
    reset = 1'b0;

    // conditional branches, taken and not taken
    run_cond("bnak_1", 4'ha, 1'b1);
    run_cond("bnak_0", 4'ha, 1'b0);
    run_cond("bc_1",   4'h9, 1'b1);
    run_cond("bc_0",   4'h9, 1'b0);
    run_cond("bz_1",   4'h8, 1'b1);
    run_cond("bz_0",   4'h8, 1'b0);

`ifdef UKP_TXTO_EN
    // abandoned request after TX_TIMEOUT=16 clks
    clear_mem();
    mem[0] = 4'h6; mem[1] = 4'hd; mem[2] = 4'h2; mem[3] = 4'he;
    do_reset();
    wait_valid(ok);
    check("to_rise", ok, 1);
    hi = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx_if.tx_valid) break;
      hi++;
    end
    check("to_len", hi, 16);
    check("to_pc", rom_adr, 0);
`endif

    // randomized programs vs instruction-level model
    for (int p = 0; p < 3; p++) begin
      for (int unsigned a = 0; a < DEPTH; a++) mem[a] = 4'($urandom);
      act_i = 1'($urandom); conn_i = 1'($urandom); nak_i = 1'($urandom);
      model_run(act_i, conn_i, nak_i);
      do_reset();
      cyc = 0; stall = 0;
      while ((q_dut.size() - q_base) < q_exp.size() && cyc < 15000) begin
        @(posedge clk); #1;
        tick_1ms = ($urandom_range(7) == 0);
        tx_if.tx_ready = (stall >= 6) ? 1'b1 : 1'($urandom);
        if (tx_if.tx_ready) stall = 0; else stall++;
        cyc++;
      end
      tx_if.tx_ready = 1'b0; tick_1ms = 1'b0;
      check("rnd_count", (q_dut.size() - q_base) >= q_exp.size(), 1);
      for (int unsigned i = 0; i < q_exp.size(); i++)
        check("rnd_event", (q_base + i < q_dut.size()) ? 32'(q_dut[q_base + i]) : 32'hffff,
              32'(q_exp[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
